// File: rtl/seg7_scan_if.sv
// Multiplexed 7-segment display bus as seen by the scan decoder: strobe, digit select,
// segment lines in, recovered per-digit values and status pulses out.
interface seg7_scan_if #(
    parameter int NUM_DIG = 4
);
    logic                   i_Muestra;
    logic [NUM_DIG-1:0]     i_Anodos;
    logic [6:0]             i_Segmentos;
    logic [4*NUM_DIG-1:0]   o_Digitos;
    logic [NUM_DIG-1:0]     o_Validos;
    logic [NUM_DIG-1:0]     o_Error;
    logic                   o_Actualizado;
    logic                   o_Scan_Err;

    modport master (
        output i_Muestra, i_Anodos, i_Segmentos,
        input  o_Digitos, o_Validos, o_Error, o_Actualizado, o_Scan_Err
    );

    modport slave (
        input  i_Muestra, i_Anodos, i_Segmentos,
        output o_Digitos, o_Validos, o_Error, o_Actualizado, o_Scan_Err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex value shown on each digit of a multiplexed 7-segment display. A digit's
// pattern is committed only after STABLE consecutive identical samples of that digit.
module seg7_scan_decoder #(
    parameter int NUM_DIG = 4,
    parameter int STABLE  = 3
) (
    input logic        i_Clk,
    input logic        i_Rst_n,
    seg7_scan_if.slave bus
);
    localparam logic [3:0] STABLE_C = 4'(STABLE);

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] value;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] seg);
        dec_t d;
        d = '{legal: 1'b1, blank: 1'b0, value: 4'h0};
        case (seg)
            7'b1111110: d.value = 4'h0;
            7'b0110000: d.value = 4'h1;
            7'b1101101: d.value = 4'h2;
            7'b1111001: d.value = 4'h3;
            7'b0110011: d.value = 4'h4;
            7'b1011011: d.value = 4'h5;
            7'b1011111: d.value = 4'h6;
            7'b1110000: d.value = 4'h7;
            7'b1111111: d.value = 4'h8;
            7'b1110011: d.value = 4'h9;
            7'b1110111: d.value = 4'hA;
            7'b0011111: d.value = 4'hB;
            7'b1001110: d.value = 4'hC;
            7'b0111101: d.value = 4'hD;
            7'b1001111: d.value = 4'hE;
            7'b1000111: d.value = 4'hF;
            7'b0000000: begin
                d.legal = 1'b0;
                d.blank = 1'b1;
            end
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    logic [6:0]           cand_q [NUM_DIG];
    logic [6:0]           cand_d [NUM_DIG];
    logic [3:0]           cnt_q  [NUM_DIG];
    logic [3:0]           cnt_d  [NUM_DIG];
    logic [4*NUM_DIG-1:0] dig_q, dig_d;
    logic [NUM_DIG-1:0]   val_q, val_d;
    logic [NUM_DIG-1:0]   err_q, err_d;
    logic                 upd_q, upd_d;
    logic                 scan_q, scan_d;

    dec_t seg_dec;
    logic one_hot;
    logic accept;

    assign seg_dec = decode(bus.i_Segmentos);
    assign one_hot = $onehot(bus.i_Anodos);
    assign accept  = bus.i_Muestra && one_hot;

    // NOTE: every variable gets its hold value first so no path through the block leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        dig_d  = dig_q;
        val_d  = val_q;
        err_d  = err_q;
        scan_d = bus.i_Muestra && !one_hot;

        for (int k = 0; k < NUM_DIG; k++) begin
            if (accept && bus.i_Anodos[k]) begin
                if (bus.i_Segmentos == cand_q[k]) begin
                    cnt_d[k] = (cnt_q[k] >= STABLE_C) ? STABLE_C : cnt_q[k] + 4'd1;
                end else begin
                    cand_d[k] = bus.i_Segmentos;
                    cnt_d[k]  = 4'd1;
                end
                // A fresh pattern with STABLE=1 commits even if the previous run was saturated.
                if (cnt_d[k] == STABLE_C &&
                    (cnt_q[k] < STABLE_C || bus.i_Segmentos != cand_q[k])) begin
                    if (seg_dec.legal) begin
                        dig_d[4*k +: 4] = seg_dec.value;
                        val_d[k]        = 1'b1;
                        err_d[k]        = 1'b0;
                    end else if (seg_dec.blank) begin
                        dig_d[4*k +: 4] = 4'h0;
                        val_d[k]        = 1'b0;
                        err_d[k]        = 1'b0;
                    end else begin
                        val_d[k]        = 1'b0;
                        err_d[k]        = 1'b1;
                    end
                end
            end
        end

        upd_d = (dig_d != dig_q) || (val_d != val_q) || (err_d != err_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; the candidate/count arrays are reset too, so partial runs are
    // discarded by reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < NUM_DIG; k++) begin
                cand_q[k] <= 7'b0;
                cnt_q[k]  <= 4'd0;
            end
            dig_q  <= '0;
            val_q  <= '0;
            err_q  <= '0;
            upd_q  <= 1'b0;
            scan_q <= 1'b0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            val_q  <= val_d;
            err_q  <= err_d;
            upd_q  <= upd_d;
            scan_q <= scan_d;
        end
    end

    assign bus.o_Digitos     = dig_q;
    assign bus.o_Validos     = val_q;
    assign bus.o_Error       = err_q;
    assign bus.o_Actualizado = upd_q;
    assign bus.o_Scan_Err    = scan_q;
endmodule
